// File: rtl/sample_scheduler.sv
// sample_scheduler: duty-cycled ADC sampling sequencer.
// Each sample goes through WAIT (the sample interval chosen by the power state), an optional
// ADC power-up SETTLE, a CONVERT handshake and a FILTER handshake, then counts the sample.
// Build option: define SAMPLE_SCHED_TIMEOUT_EN to compile in the CONVERT/FILTER watchdog.
// Without it the handshakes wait indefinitely and timeout_err is tied low.
module sample_scheduler #(
    parameter int unsigned SETTLE_CYCLES  = 8,    // 1..255
    parameter int unsigned TIMEOUT_CYCLES = 255   // 1..65535
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  power_state,
    input  logic [15:0] sample_period,
    output logic        adc_power_req,
    output logic        adc_start,
    input  logic        adc_done,
    output logic        filter_start,
    input  logic        filter_done,
    output logic        sample_valid,
    output logic        timeout_err,
    output logic        busy,
    output logic [15:0] sample_count
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT,
        ST_SETTLE,
        ST_CONVERT,
        ST_FILTER
    } state_t;

    localparam logic [1:0] PS_SLEEP  = 2'b00;
    localparam logic [1:0] PS_IDLE   = 2'b01;
    localparam logic [1:0] PS_ACTIVE = 2'b10;

    // Counters are loaded with "length - 1" and the state is left when they reach zero.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_period_cnt;
    logic [7:0]  r_settle_cnt;
    logic        r_adc_start;
    logic        r_filter_start;
    logic        r_sample_valid;
    logic        r_timeout_err;
    logic [15:0] r_sample_count;

    logic        w_run;
    logic        w_power_req;
    logic [15:0] w_period;
    logic [15:0] w_period_last;
    logic        w_wdog_expired;

    // The scheduler only runs when enabled and the power manager is not asleep.
    assign w_run = enable && (power_state != PS_SLEEP);

    // Effective WAIT length for a WAIT entry on the coming edge, from the current power state.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        w_period = 16'd1;
        case (power_state)
            PS_IDLE:   w_period = sample_period;
            PS_ACTIVE: w_period = sample_period >> 2;
            default:   w_period = 16'd1;
        endcase
        if (w_period == 16'd0) begin
            w_period = 16'd1;
        end
    end

    assign w_period_last = w_period - 16'd1;

    // ADC power request: off in OFF, follows the live power state in WAIT, held on while sampling.
    always_comb begin
        w_power_req = 1'b1;
        case (r_state)
            ST_OFF:  w_power_req = 1'b0;
            ST_WAIT: w_power_req = (power_state != PS_IDLE);
            default: w_power_req = 1'b1;
        endcase
    end

`ifdef SAMPLE_SCHED_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog_cnt;
    logic        w_in_handshake;
    logic        w_handshake_end;

    assign w_in_handshake  = (r_state == ST_CONVERT) || (r_state == ST_FILTER);
    assign w_wdog_expired  = w_in_handshake && (r_wdog_cnt == TIMEOUT_LAST);
    assign w_handshake_end = ((r_state == ST_CONVERT) && adc_done)
                          || ((r_state == ST_FILTER) && filter_done)
                          || w_wdog_expired;

    // Watchdog: cycles spent in the current CONVERT or FILTER visit, zero on every entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog_cnt <= '0;
        end else if (!w_run || !w_in_handshake || w_handshake_end) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end
`else
    assign w_wdog_expired = 1'b0;
`endif

    // Sequencer FSM with its counters and the registered strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_OFF;
            r_period_cnt   <= '0;
            r_settle_cnt   <= '0;
            r_adc_start    <= 1'b0;
            r_filter_start <= 1'b0;
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_sample_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
            r_adc_start    <= 1'b0;
            r_filter_start <= 1'b0;
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b0;

            if (!w_run) begin
                // Abort: drop the sequence without completing the sample; the count is kept.
                r_state      <= ST_OFF;
                r_period_cnt <= '0;
                r_settle_cnt <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state      <= ST_WAIT;
                        r_period_cnt <= w_period_last;
                    end

                    ST_WAIT: begin
                        if (r_period_cnt == 16'd0) begin
                            if (!w_power_req) begin
                                // ADC was unpowered in the last WAIT cycle: let it settle first.
                                r_state      <= ST_SETTLE;
                                r_settle_cnt <= SETTLE_LAST;
                            end else begin
                                r_state     <= ST_CONVERT;
                                r_adc_start <= 1'b1;
                            end
                        end else begin
                            r_period_cnt <= r_period_cnt - 16'd1;
                        end
                    end

                    ST_SETTLE: begin
                        if (r_settle_cnt == 8'd0) begin
                            r_state     <= ST_CONVERT;
                            r_adc_start <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 8'd1;
                        end
                    end

                    ST_CONVERT: begin
                        // A done arriving on the expiry cycle still wins over the watchdog.
                        if (adc_done) begin
                            r_state        <= ST_FILTER;
                            r_filter_start <= 1'b1;
                        end else if (w_wdog_expired) begin
                            r_state       <= ST_WAIT;
                            r_period_cnt  <= w_period_last;
                            r_timeout_err <= 1'b1;
                        end
                    end

                    ST_FILTER: begin
                        if (filter_done) begin
                            r_state        <= ST_WAIT;
                            r_period_cnt   <= w_period_last;
                            r_sample_valid <= 1'b1;
                            r_sample_count <= r_sample_count + 16'd1;
                        end else if (w_wdog_expired) begin
                            r_state       <= ST_WAIT;
                            r_period_cnt  <= w_period_last;
                            r_timeout_err <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_OFF;
                    end
                endcase
            end
        end
    end

    assign adc_power_req = w_power_req;
    assign adc_start     = r_adc_start;
    assign filter_start  = r_filter_start;
    assign sample_valid  = r_sample_valid;
    assign timeout_err   = r_timeout_err;
    assign sample_count  = r_sample_count;
    assign busy          = (r_state == ST_SETTLE) || (r_state == ST_CONVERT) || (r_state == ST_FILTER);

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: self-checking bench for sample_scheduler.
// The reference model predicts each sample as a schedule of phases (WAIT length from the power
// state, optional settle, handshake lengths chosen by the bench) and compares the outputs cycle
// by cycle. Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_sample_scheduler;

    localparam int ST = 8;
    localparam int TO = 255;

    localparam logic [1:0] PS_SLEEP  = 2'b00;
    localparam logic [1:0] PS_IDLE   = 2'b01;
    localparam logic [1:0] PS_ACTIVE = 2'b10;
    localparam logic [1:0] PS_HP     = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  power_state = 2'b00;
    logic [15:0] sample_period = 16'd0;
    logic        adc_done = 1'b0;
    logic        filter_done = 1'b0;
    logic        adc_power_req;
    logic        adc_start;
    logic        filter_start;
    logic        sample_valid;
    logic        timeout_err;
    logic        busy;
    logic [15:0] sample_count;

    logic [5:0]  outs;
    assign outs = {adc_power_req, busy, adc_start, filter_start, sample_valid, timeout_err};

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_count = 16'd0;
    logic        m_valid_due = 1'b0;
    logic        m_err_due = 1'b0;

    always #5 clock = ~clock;

    sample_scheduler #(
        .SETTLE_CYCLES (ST),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .power_state  (power_state),
        .sample_period(sample_period),
        .adc_power_req(adc_power_req),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .filter_start (filter_start),
        .filter_done  (filter_done),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err),
        .busy         (busy),
        .sample_count (sample_count)
    );

    function automatic int eff_period(input logic [1:0] ps, input logic [15:0] sp);
        int p;
        case (ps)
            PS_IDLE:   p = int'(sp);
            PS_ACTIVE: p = int'(sp) / 4;
            default:   p = 1;
        endcase
        if (p == 0) p = 1;
        return p;
    endfunction

    function automatic logic [5:0] pack(input logic req, input logic bsy, input logic as,
                                        input logic fs, input logic sv, input logic te);
        return {req, bsy, as, fs, sv, te};
    endfunction

    task automatic apply_reset(input logic en, input logic [1:0] ps, input logic [15:0] sp);
        @(negedge clock);
        reset_n       = 1'b0;
        enable        = en;
        power_state   = ps;
        sample_period = sp;
        adc_done      = 1'b0;
        filter_done   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n     = 1'b1;
        m_count     = 16'd0;
        m_valid_due = 1'b0;
        m_err_due   = 1'b0;
    endtask

    // Called on the falling edge just before the edge that enters WAIT. Runs one full sample
    // and returns on the falling edge of the last FILTER cycle with filter_done driven high.
    task automatic run_sample(input logic [1:0] ps, input logic [15:0] sp, input int d_c,
                              input int d_f, input logic [1:0] ps_mid, input string tag);
        int         p;
        logic [5:0] exp;
        p = eff_period(ps, sp);
        power_state   = ps;
        sample_period = sp;
        for (int i = 0; i < p; i++) begin
            @(negedge clock);
            adc_done    = 1'($urandom_range(0, 1));
            filter_done = 1'($urandom_range(0, 1));
            exp = pack(ps != PS_IDLE, 1'b0, 1'b0, 1'b0, (i == 0) && m_valid_due, (i == 0) && m_err_due);
            n_vec++;
            if (outs !== exp || sample_count !== m_count) begin
                n_err++;
                $display("FAIL %s wait[%0d]: got outs=%b count=%h, want outs=%b count=%h",
                         tag, i, outs, sample_count, exp, m_count);
            end
        end
        m_valid_due = 1'b0;
        m_err_due   = 1'b0;
        if (ps == PS_IDLE) begin
            for (int i = 0; i < ST; i++) begin
                @(negedge clock);
                adc_done    = 1'($urandom_range(0, 1));
                filter_done = 1'($urandom_range(0, 1));
                exp = pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                n_vec++;
                if (outs !== exp || sample_count !== m_count) begin
                    n_err++;
                    $display("FAIL %s settle[%0d]: got outs=%b count=%h, want outs=%b count=%h",
                             tag, i, outs, sample_count, exp, m_count);
                end
            end
        end
        for (int j = 0; j <= d_c; j++) begin
            @(negedge clock);
            adc_done    = 1'b0;
            filter_done = 1'($urandom_range(0, 1));
            exp = pack(1'b1, 1'b1, j == 0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (outs !== exp || sample_count !== m_count) begin
                n_err++;
                $display("FAIL %s convert[%0d]: got outs=%b count=%h, want outs=%b count=%h",
                         tag, j, outs, sample_count, exp, m_count);
            end
            if (j == 0) power_state = ps_mid;
            if (j == d_c) adc_done = 1'b1;
        end
        for (int j = 0; j <= d_f; j++) begin
            @(negedge clock);
            filter_done = 1'b0;
            adc_done    = 1'($urandom_range(0, 1));
            exp = pack(1'b1, 1'b1, 1'b0, j == 0, 1'b0, 1'b0);
            n_vec++;
            if (outs !== exp || sample_count !== m_count) begin
                n_err++;
                $display("FAIL %s filter[%0d]: got outs=%b count=%h, want outs=%b count=%h",
                         tag, j, outs, sample_count, exp, m_count);
            end
            if (j == d_f) begin
                filter_done = 1'b1;
                m_count     = m_count + 16'd1;
                m_valid_due = 1'b1;
            end
        end
    endtask

    // Checks the first WAIT cycle after a completed (or timed-out) handshake.
    task automatic expect_wait_entry(input string tag);
        logic [5:0] exp;
        @(negedge clock);
        adc_done    = 1'b0;
        filter_done = 1'b0;
        exp = pack(power_state != PS_IDLE, 1'b0, 1'b0, 1'b0, m_valid_due, m_err_due);
        n_vec++;
        if (outs !== exp || sample_count !== m_count) begin
            n_err++;
            $display("FAIL %s: got outs=%b count=%h, want outs=%b count=%h",
                     tag, outs, sample_count, exp, m_count);
        end
        m_valid_due = 1'b0;
        m_err_due   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        enable      = 1'b1;
        power_state = PS_HP;
        adc_done    = 1'b1;
        filter_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_vec++;
            if (outs !== 6'b0 || sample_count !== 16'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got outs=%b count=%h, want outs=000000 count=0000",
                         i, outs, sample_count);
            end
        end
        adc_done    = 1'b0;
        filter_done = 1'b0;
        reset_n     = 1'b1;
        m_count     = 16'd0;
        run_sample(PS_HP, 16'd0, 2, 1, PS_HP, "reset_first");
        expect_wait_entry("reset_first_end");
        @(negedge clock);
        n_vec++;
        if (outs !== pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_pre_abort: got outs=%b, want outs=111000", outs);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (outs !== 6'b0 || sample_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_async: got outs=%b count=%h, want outs=000000 count=0000",
                     outs, sample_count);
        end
        @(negedge clock);
        reset_n     = 1'b1;
        m_count     = 16'd0;
        m_valid_due = 1'b0;
        m_err_due   = 1'b0;
        run_sample(PS_IDLE, 16'd3, 1, 2, PS_ACTIVE, "reset_restart");
        expect_wait_entry("reset_restart_end");
    endtask

    task automatic test_idle_settle();
        apply_reset(1'b1, PS_IDLE, 16'd100);
        run_sample(PS_IDLE, 16'd100, 0, 0, PS_IDLE, "idle_settle");
        expect_wait_entry("idle_settle_end");
    endtask

    task automatic test_active();
        apply_reset(1'b1, PS_ACTIVE, 16'd100);
        run_sample(PS_ACTIVE, 16'd100, 3, 3, PS_ACTIVE, "active");
        expect_wait_entry("active_end");
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b1, PS_HP, 16'd0);
        for (int k = 0; k < 5; k++) begin
            run_sample(PS_HP, 16'($urandom), 1, 1, PS_HP, "back_to_back");
        end
        expect_wait_entry("back_to_back_end");
    endtask

    task automatic test_abort();
        apply_reset(1'b1, PS_HP, 16'd0);
        @(negedge clock);
        n_vec++;
        if (outs !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL abort_wait: got outs=%b, want outs=100000", outs);
        end
        @(negedge clock);
        n_vec++;
        if (outs !== pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL abort_convert: got outs=%b, want outs=111000", outs);
        end
        adc_done = 1'b1;
        @(negedge clock);
        adc_done = 1'b0;
        n_vec++;
        if (outs !== pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL abort_filter: got outs=%b, want outs=110100", outs);
        end
        enable      = 1'b0;
        filter_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            filter_done = 1'b0;
            n_vec++;
            if (outs !== 6'b0 || sample_count !== m_count) begin
                n_err++;
                $display("FAIL abort_off[%0d]: got outs=%b count=%h, want outs=000000 count=%h",
                         i, outs, sample_count, m_count);
            end
        end
        enable = 1'b1;
        run_sample(PS_ACTIVE, 16'd20, 0, 0, PS_IDLE, "abort_resume");
        expect_wait_entry("abort_resume_end");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_vec++;
            if (outs !== 6'b0 || sample_count !== m_count) begin
                n_err++;
                $display("FAIL abort_midwait[%0d]: got outs=%b count=%h, want outs=000000 count=%h",
                         i, outs, sample_count, m_count);
            end
        end
        power_state = PS_SLEEP;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_vec++;
            if (outs !== 6'b0 || sample_count !== m_count) begin
                n_err++;
                $display("FAIL abort_sleep[%0d]: got outs=%b count=%h, want outs=000000 count=%h",
                         i, outs, sample_count, m_count);
            end
        end
        run_sample(PS_IDLE, 16'd20, 2, 0, PS_HP, "abort_rewait");
        expect_wait_entry("abort_rewait_end");
    endtask

    task automatic test_random();
        apply_reset(1'b1, PS_HP, 16'd0);
        for (int k = 0; k < 25; k++) begin
            run_sample(2'($urandom_range(1, 3)), 16'($urandom_range(0, 40)),
                       $urandom_range(0, 5), $urandom_range(0, 5),
                       2'($urandom_range(1, 3)), "random");
        end
        expect_wait_entry("random_end");
    endtask

    task automatic test_count_wrap();
        apply_reset(1'b0, PS_HP, 16'd0);
        @(negedge clock);
        force dut.r_sample_count = 16'hFFFE;
        #1;
        release dut.r_sample_count;
        m_count = 16'hFFFE;
        @(negedge clock);
        n_vec++;
        if (outs !== 6'b0 || sample_count !== m_count) begin
            n_err++;
            $display("FAIL wrap_preload: got outs=%b count=%h, want outs=000000 count=%h",
                     outs, sample_count, m_count);
        end
        enable = 1'b1;
        run_sample(PS_HP, 16'd0, 0, 0, PS_HP, "wrap_a");
        run_sample(PS_HP, 16'd0, 0, 0, PS_HP, "wrap_b");
        expect_wait_entry("wrap_end");
    endtask

    task automatic test_watchdog();
`ifdef SAMPLE_SCHED_TIMEOUT_EN
        apply_reset(1'b1, PS_HP, 16'd0);
        @(negedge clock);
        filter_done = 1'b1;
        n_vec++;
        if (outs !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL wdog_wait: got outs=%b, want outs=100000", outs);
        end
        for (int k = 0; k < TO; k++) begin
            @(negedge clock);
            n_vec++;
            if (outs !== pack(1'b1, 1'b1, k == 0, 1'b0, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL wdog_convert[%0d]: got outs=%b, want outs=%b",
                         k, outs, pack(1'b1, 1'b1, k == 0, 1'b0, 1'b0, 1'b0));
            end
        end
        m_err_due = 1'b1;
        expect_wait_entry("wdog_convert_expired");
        @(negedge clock);
        n_vec++;
        if (outs !== pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL wdog_restart: got outs=%b, want outs=111000", outs);
        end
        adc_done = 1'b1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clock);
            adc_done = 1'b0;
            n_vec++;
            if (outs !== pack(1'b1, 1'b1, 1'b0, k == 0, 1'b0, 1'b0) || sample_count !== m_count) begin
                n_err++;
                $display("FAIL wdog_filter[%0d]: got outs=%b count=%h, want outs=%b count=%h",
                         k, outs, sample_count, pack(1'b1, 1'b1, 1'b0, k == 0, 1'b0, 1'b0), m_count);
            end
        end
        m_err_due = 1'b1;
        run_sample(PS_HP, 16'd0, TO - 1, TO - 1, PS_HP, "wdog_done_wins");
        expect_wait_entry("wdog_done_wins_end");
`else
        apply_reset(1'b1, PS_HP, 16'd0);
        run_sample(PS_HP, 16'd0, 300, 300, PS_HP, "no_wdog");
        expect_wait_entry("no_wdog_end");
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish within its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        test_reset();
        test_idle_settle();
        test_active();
        test_back_to_back();
        test_abort();
        test_random();
        test_count_wrap();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: ADC power-up settle time in clock cycles, legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit for CONVERT and FILTER, legal range 1..65535.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  scheduler enable.
REQ-006 power_state  in  2  00 SLEEP, 01 IDLE, 10 ACTIVE, 11 HIGH_PERF; comes from the power manager.
REQ-007 sample_period  in  16  IDLE sample interval in cycles.
REQ-008 adc_power_req  out  1  ADC power request.
REQ-009 adc_start  out  1  conversion start, one-cycle pulse.
REQ-010 adc_done  in  1  conversion complete, one-cycle pulse.
REQ-011 filter_start  out  1  filter start, one-cycle pulse.
REQ-012 filter_done  in  1  filter complete, one-cycle pulse.
REQ-013 sample_valid  out  1  sample completed, one-cycle pulse.
REQ-014 timeout_err  out  1  watchdog expired, one-cycle pulse.
REQ-015 busy  out  1  high in SETTLE, CONVERT or FILTER.
REQ-016 sample_count  out  16  count of completed samples.

Function
REQ-017 The block SHALL contain a registered FSM with the states OFF, WAIT, SETTLE, CONVERT and FILTER.
REQ-018 The run condition "run" SHALL be true when enable=1 and power_state is not 00.
REQ-019 From any state, when run is false, the FSM SHALL go to OFF on the next edge. This abort SHALL clear the period, settle and watchdog counters and SHALL NOT generate sample_valid.
REQ-020 The transition OFF->WAIT SHALL occur on the first edge at which run is true.
REQ-021 The effective period P SHALL be selected by power_state at WAIT entry:
- IDLE: sample_period.
- ACTIVE: sample_period>>2.
- HIGH_PERF: 1.
- Any result of 0 SHALL be treated as 1.
REQ-022 The FSM SHALL remain in WAIT for exactly P cycles and then leave it.
REQ-023 On leaving WAIT, the FSM SHALL go to SETTLE if adc_power_req was 0 during the last WAIT cycle, and to CONVERT otherwise.
REQ-024 adc_power_req SHALL be 0 in OFF. In WAIT it SHALL be 0 while the current power_state is IDLE and 1 otherwise. In SETTLE, CONVERT and FILTER it SHALL be 1.
REQ-025 The FSM SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles and then go to CONVERT.
REQ-026 adc_start SHALL be high only during the first cycle in CONVERT.
REQ-027 When adc_done=1 is sampled in CONVERT, the FSM SHALL go to FILTER.
REQ-028 filter_start SHALL be high only during the first cycle in FILTER.
REQ-029 When filter_done=1 is sampled in FILTER, the FSM SHALL go to WAIT.
REQ-030 On that FILTER->WAIT transition, sample_valid SHALL pulse during the first WAIT cycle and sample_count SHALL increment on the same edge.
REQ-031 sample_count SHALL wrap from 0xFFFF to 0x0000.
REQ-032 adc_done sampled outside CONVERT and filter_done sampled outside FILTER SHALL be ignored.
REQ-033 A power_state change while in SETTLE, CONVERT or FILTER SHALL NOT alter the sequence in progress; the new value takes effect at the next WAIT entry.
REQ-034 adc_start, filter_start, sample_valid and timeout_err SHALL all be driven from registers.

Reset
REQ-035 While reset_n=0, the FSM SHALL be in OFF, all counters SHALL be 0 and every output SHALL be 0.
REQ-036 Reset assertion SHALL take effect immediately, including mid-sequence.
REQ-037 After reset_n deasserts, the first transition SHALL be OFF->WAIT per REQ-020.

Configuration
REQ-038 The watchdog SHALL be compiled in when SAMPLE_SCHED_TIMEOUT_EN is defined.
REQ-039 With the watchdog compiled in:
- A counter SHALL clear on entry to CONVERT and on entry to FILTER.
- If the matching done signal is not sampled within TIMEOUT_CYCLES cycles of entry, the FSM SHALL go to WAIT.
- On that transition timeout_err SHALL pulse for one cycle, with no sample_valid and no sample_count increment.
- If done and expiry occur in the same cycle, done SHALL win.
REQ-040 Without the macro, CONVERT and FILTER SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-041 Directed scenarios:
- Reset, enable=1, power_state=01, sample_period=100 -> 100 WAIT cycles with adc_power_req=0, then 8 SETTLE cycles, then an adc_start pulse.
- power_state=10, sample_period=100, done signals returned 3 cycles after each start -> 25 WAIT cycles, no SETTLE, adc_power_req held at 1, sample_valid pulses, sample_count=1.
- power_state=11, both done signals returned on the cycle after each start -> back-to-back samples, 1 WAIT cycle between them.
- sample_count preloaded by running 65536 samples -> sample_count reads 0x0000.
- enable dropped in FILTER -> OFF on the next edge, all outputs 0, no sample_valid.
- Macro defined, TIMEOUT_CYCLES=255, adc_done withheld -> timeout_err pulses 255 cycles after adc_start, sample_count unchanged.
